// File: rtl/result_drain.sv
// Output stage for the 2x2 systolic array: captures a tile on each clear and streams it as bytes.
// Optional macro RESULT_DRAIN_SAT8_EN: saturate each element to int8 and send 4 bytes per tile.
module result_drain #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] c00,
    input  logic [DATA_W-1:0] c01,
    input  logic [DATA_W-1:0] c10,
    input  logic [DATA_W-1:0] c11,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              overrun
);

`ifdef RESULT_DRAIN_SAT8_EN
    localparam int ELEM_W = 8;
    localparam int IDX_W  = 2;
`else
    localparam int ELEM_W = 16;
    localparam int IDX_W  = 3;
`endif

    typedef logic [3:0][ELEM_W-1:0] tile_t;
    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic [7:0] sat8(input logic signed [15:0] v);
        if (v > 16'sd127)
            return 8'h7F;
        else if (v < -16'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

    function automatic logic [7:0] pick(input tile_t t, input logic [IDX_W-1:0] idx);
`ifdef RESULT_DRAIN_SAT8_EN
        return t[idx];
`else
        return idx[0] ? t[idx[2:1]][15:8] : t[idx[2:1]][7:0];
`endif
    endfunction

    logic signed [15:0] ext [4];
    tile_t              new_tile;

    assign ext[0] = 16'($signed(c00));
    assign ext[1] = 16'($signed(c01));
    assign ext[2] = 16'($signed(c10));
    assign ext[3] = 16'($signed(c11));

    always_comb begin
        new_tile = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef RESULT_DRAIN_SAT8_EN
            new_tile[i] = sat8(ext[i]);
`else
            new_tile[i] = ext[i];
`endif
        end
    end

    state_t           state, state_n;
    logic             armed, armed_n;
    logic             overrun_n;
    logic             shadow_full, shadow_full_n;
    tile_t            drain, drain_n;
    tile_t            shadow, shadow_n;
    logic [IDX_W-1:0] idx, idx_n;

    logic capture;
    logic accept;
    logic last_accept;

    assign capture     = enable && clear && armed;
    assign accept      = (state == SEND) && out_ready;
    assign last_accept = accept && (idx == {IDX_W{1'b1}});

    // The shadow frees up on last-byte acceptance, so a coinciding capture never overruns.
    always_comb begin
        state_n       = state;
        armed_n       = armed;
        overrun_n     = overrun;
        shadow_full_n = shadow_full;
        drain_n       = drain;
        shadow_n      = shadow;
        idx_n         = idx;
        if (!enable) begin
            state_n       = IDLE;
            armed_n       = 1'b0;
            overrun_n     = 1'b0;
            shadow_full_n = 1'b0;
            idx_n         = '0;
        end else begin
            if (clear)
                armed_n = 1'b1;
            if (state == IDLE) begin
                if (capture) begin
                    drain_n = new_tile;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end else begin
                if (accept)
                    idx_n = idx + IDX_W'(1);
                if (last_accept) begin
                    if (shadow_full) begin
                        drain_n       = shadow;
                        idx_n         = '0;
                        shadow_full_n = 1'b0;
                    end else if (!capture) begin
                        state_n = IDLE;
                    end
                end
                if (capture) begin
                    if (last_accept && !shadow_full) begin
                        drain_n = new_tile;
                        idx_n   = '0;
                    end else if (!shadow_full || last_accept) begin
                        shadow_n      = new_tile;
                        shadow_full_n = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            overrun     <= 1'b0;
            shadow_full <= 1'b0;
            drain       <= '0;
            shadow      <= '0;
            idx         <= '0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
        end else begin
            state       <= state_n;
            armed       <= armed_n;
            overrun     <= overrun_n;
            shadow_full <= shadow_full_n;
            drain       <= drain_n;
            shadow      <= shadow_n;
            idx         <= idx_n;
            out_valid   <= (state_n == SEND);
            out_data    <= (state_n == SEND) ? pick(drain_n, idx_n) : 8'h00;
        end
    end

    assign busy = (state == SEND) || shadow_full;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: arming, streaming, backpressure, coincident events, flush.
// Runs the saturating scenario instead when RESULT_DRAIN_SAT8_EN is defined.
module tb_result_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [15:0] c00, c01, c10, c11;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;

    result_drain #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        c00 = a;
        c01 = b;
        c10 = c;
        c11 = d;
    endtask

    task automatic rearm;
        enable = 1'b0;
        clear  = 1'b0;
        step();
        enable = 1'b1;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; out_ready = 1'b0;
        set_tile(16'h0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: got valid=%b data=%h busy=%b ovr=%b, expected 0 00 0 0",
                     out_valid, out_data, busy, overrun);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_arming;
        enable = 1'b1;
        out_ready = 1'b1;
        set_tile(16'd1, 16'd2, 16'd3, 16'd4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL arming: got valid=%b busy=%b, expected 0 0", out_valid, busy);
            end
            step();
        end
    endtask

`ifdef RESULT_DRAIN_SAT8_EN
    task automatic test_sat8;
        logic [7:0] exp_b [4] = '{8'h7F, 8'h80, 8'hFB, 8'h7F};
        out_ready = 1'b1;
        set_tile(16'd300, 16'hFED4, 16'hFFFB, 16'd127);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin
                miscompares++;
                $display("[TB] FAIL sat8 byte %0d: got valid=%b data=%h, expected 1 %h",
                         i, out_valid, out_data, exp_b[i]);
            end
            step();
        end
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sat8 idle: got valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
    endtask
`else
    task automatic test_stream;
        logic [7:0] exp_b [8] = '{8'h02, 8'h01, 8'hFE, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'h7F};
        out_ready = 1'b1;
        set_tile(16'h0102, 16'hFFFE, 16'h0080, 16'h7FFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin
                miscompares++;
                $display("[TB] FAIL stream byte %0d: got valid=%b data=%h, expected 1 %h",
                         i, out_valid, out_data, exp_b[i]);
            end
            step();
        end
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream end: got valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_b [16] = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77,
                                   8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5, 8'h17, 8'h08};
        logic [7:0] got [$];
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = 8'h00;
        for (int k = 0; k < 40; k++) begin
            if (pv && !pr) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== pd) begin
                    miscompares++;
                    $display("[TB] FAIL bp hold k=%0d: got valid=%b data=%h, expected 1 %h",
                             k, out_valid, out_data, pd);
                end
            end
            if (k == 12 || k == 13) begin
                vectors++;
                if (overrun !== (k == 13)) begin
                    miscompares++;
                    $display("[TB] FAIL bp overrun k=%0d: got %b, expected %b", k, overrun, k == 13);
                end
            end
            clear = (k == 0 || k == 8 || k == 12);
            if (k == 0)  set_tile(16'h1122, 16'h3344, 16'h5566, 16'h7788);
            if (k == 8)  set_tile(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0817);
            if (k == 12) set_tile(16'h9999, 16'h9999, 16'h9999, 16'h9999);
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            if (out_valid && out_ready)
                got.push_back(out_data);
            pv = out_valid;
            pd = out_data;
            pr = out_ready;
            step();
        end
        clear = 1'b0;
        vectors++;
        if (got.size() != 16) begin
            miscompares++;
            $display("[TB] FAIL bp count: got %0d bytes, expected 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_b[i]) begin
                miscompares++;
                $display("[TB] FAIL bp byte %0d: got %h, expected %h", i, got[i], exp_b[i]);
            end
        end
        vectors++;
        if (overrun !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp end: got ovr=%b valid=%b busy=%b, expected 1 0 0",
                     overrun, out_valid, busy);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp_b [32] = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77,
                                   8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5, 8'h17, 8'h08,
                                   8'h0B, 8'h0A, 8'h0D, 8'h0C, 8'h0F, 8'h0E, 8'h11, 8'h10,
                                   8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        logic [7:0] got [$];
        rearm();
        out_ready = 1'b1;
        for (int k = 0; k < 34; k++) begin
            vectors++;
            if (out_valid !== (k >= 1 && k <= 32)) begin
                miscompares++;
                $display("[TB] FAIL simul valid k=%0d: got %b, expected %b",
                         k, out_valid, (k >= 1 && k <= 32));
            end
            clear = (k == 0 || k == 3 || k == 8 || k == 24);
            if (k == 0)  set_tile(16'h1122, 16'h3344, 16'h5566, 16'h7788);
            if (k == 3)  set_tile(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0817);
            if (k == 8)  set_tile(16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011);
            if (k == 24) set_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
            if (out_valid && out_ready)
                got.push_back(out_data);
            step();
        end
        clear = 1'b0;
        vectors++;
        if (got.size() != 32) begin
            miscompares++;
            $display("[TB] FAIL simul count: got %0d bytes, expected 32", got.size());
        end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_b[i]) begin
                miscompares++;
                $display("[TB] FAIL simul byte %0d: got %h, expected %h", i, got[i], exp_b[i]);
            end
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL simul overrun: got %b, expected 0", overrun);
        end
    endtask

    task automatic test_flush;
        rearm();
        out_ready = 1'b1;
        set_tile(16'h1122, 16'h3344, 16'h5566, 16'h7788);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (3) step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h33) begin
            miscompares++;
            $display("[TB] FAIL flush pre: got valid=%b data=%h, expected 1 33", out_valid, out_data);
        end
        out_ready = 1'b0;
        clear = 1'b1;
        set_tile(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0817);
        step();
        set_tile(16'h9999, 16'h9999, 16'h9999, 16'h9999);
        step();
        clear = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || busy !== 1'b1 || out_data !== 8'h33) begin
            miscompares++;
            $display("[TB] FAIL flush stall: got ovr=%b busy=%b data=%h, expected 1 1 33",
                     overrun, busy, out_data);
        end
        enable = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush: got valid=%b busy=%b ovr=%b, expected 0 0 0",
                     out_valid, busy, overrun);
        end
        enable = 1'b1;
        out_ready = 1'b1;
        clear = 1'b1;
        set_tile(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0817);
        step();
        clear = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush rearm: got valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
        clear = 1'b1;
        set_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        step();
        clear = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL flush recapture: got valid=%b data=%h, expected 1 01",
                     out_valid, out_data);
        end
        repeat (9) step();
    endtask
`endif

    initial begin
        test_reset();
        test_arming();
`ifdef RESULT_DRAIN_SAT8_EN
        test_sat8();
`else
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
